mccu: RTL and testbench
=======================

# mccu

Multicycle control unit for the MIPS datapath. A five-state FSM sequences fetch, decode, execute, memory and write-back over a shared ALU and a single memory port. It drives the 4-bit ALU operation code and all datapath selects and write enables, and uses the ALU zero flag to resolve branches. A ready handshake on the memory port stretches fetch and memory cycles.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], valid from ID onward
- func  in  6  IR[5:0]
- z  in  1  ALU zero flag
- mready  in  1  memory-port ready; completes the current IF/MEM access
- aluc  out  4  ALU op: 0000 add, 0100 sub, 0001 and, 0101 or, 0010 xor, 0110 lui, 0011 sll, 0111 srl, 1111 sra
- wpc, wir, wmem, wreg  out  1 each  PC, IR, memory and register-file write enables
- iord  out  1  memory address: 0 = PC, 1 = ALU-out register
- alusrca  out  1  ALU A: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B: 00 reg B, 01 constant 4, 10 extended imm, 11 sext(imm)<<2
- pcsource  out  2  PC input: 00 ALU, 01 ALU-out (branch target), 10 reg A (jr), 11 jump address
- regdst, m2reg, sext, shift, jal  out  1 each  rd/rt select, memory-to-reg, sign extend, sa-as-A, $31 and PC+4 write
- ill  out  1  illegal instruction; present only with MCCU_ILLEGAL_TRAP_EN

## Operation
- States: IF, ID, EXE, MEM, WB (plus HALT with the trap macro). Supported instructions: add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal.
- IF: iord=0, alusrca=0, alusrcb=01, aluc=add, pcsource=00, wpc=wir=mready. Stay in IF while mready=0; go to ID when mready=1.
- ID: aluc=add, alusrca=0, alusrcb=11, which precomputes the branch target into ALU-out.
  - j: pcsource=11, wpc=1, then IF.
  - jal: same as j, plus wreg=1 and jal=1, then IF.
  - jr: pcsource=10, wpc=1, then IF.
  - Undefined op/func: nop, then IF.
  - All other instructions: EXE.
- EXE:
  - R-type: alusrca=1, alusrcb=00, then WB. For shifts, shift=1 and alusrca is don't-care.
  - I-type ALU ops and lw/sw: alusrcb=10. sext=1 for addi/lw/sw, 0 for andi/ori/xori/lui. ALU ops go to WB; lw/sw go to MEM.
  - beq/bne: aluc=sub, alusrca=1, alusrcb=00, pcsource=01, wpc=(beq&z)|(bne&~z), then IF.
- MEM: iord=1. sw holds wmem=1 until mready, then IF. lw waits for mready, then WB.
- WB: wreg=1, m2reg=lw, regdst=1 for R-type and 0 otherwise, then IF.
- Every output not listed for a state is 0.

## Timing
- All outputs are combinational from the state register, op, func, z and mready. The only register is the state.
- Latency in cycles with mready tied high: j/jal/jr 2, beq/bne 3, R-type/I-ALU/sw 4, lw 5. Each mready-low cycle in IF or MEM adds one cycle.
- Reset: while rst=1, wpc, wir, wmem and wreg are forced to 0. The state becomes IF on the next edge, including mid-instruction and mid-handshake. After rst deasserts, the first cycle is IF.
- A wait in IF or MEM holds every output stable until mready rises.
- A branch-not-taken still advances to IF after EXE, with wpc=0.

## Configuration
- MCCU_ILLEGAL_TRAP_EN defined:
  - An undefined op/func in ID asserts ill and enters HALT.
  - HALT holds all enables at 0 and ill=1 until rst.
- MCCU_ILLEGAL_TRAP_EN undefined: an undefined instruction is a 2-cycle nop, and the ill port is absent.

## Structure
- Shared package/include mips_pkg holds the state encodings, the opcode and func constants, and the aluc constants listed above. The ALU decodes the same aluc constants.
- One sub-module, mccu_decode: purely combinational. It maps op/func to a one-hot instruction vector plus aluc/sext/shift. The FSM in mccu consumes that vector.

## Test plan
- add (op=0, func=0x20), mready=1: IF,ID,EXE,WB. EXE shows aluc=0000, alusrcb=00. WB shows wreg=1, regdst=1. Total 4 cycles.
- lw with mready low 2 cycles in MEM: iord=1 held for 3 cycles, then WB with m2reg=1, wreg=1, regdst=0. Total 7 cycles.
- beq with z=1, then with z=0: EXE shows aluc=0100 and wpc=1/0 respectively, pcsource=01. Next state IF.
- jal: ID shows pcsource=11, wpc=1, wreg=1, jal=1. Back in IF after 2 cycles.
- rst asserted during MEM of sw: wmem=0 in the same cycle. IF on the next edge, with IF outputs after release.
- op=0x3F: with the macro, ill=1 and HALT persists 10 cycles with all enables 0 until rst. Without the macro, returns to IF after ID.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: FSM state encodings, opcode/func codes, ALU op codes,
// datapath select encodings and the one-hot decoded-instruction struct.
// Used by mccu, mccu_decode and the ALU (which decodes the same aluc values).
package mips_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  // ALU operation codes
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // ALU B-input select
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  // PC input select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_REGA   = 2'b10;
  localparam logic [1:0] PCSRC_JUMP   = 2'b11;

  // One-hot decoded instruction; all-zero means undefined op/func.
  typedef struct packed {
    logic is_add;
    logic is_sub;
    logic is_and;
    logic is_or;
    logic is_xor;
    logic is_sll;
    logic is_srl;
    logic is_sra;
    logic is_jr;
    logic is_addi;
    logic is_andi;
    logic is_ori;
    logic is_xori;
    logic is_lui;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_j;
    logic is_jal;
  } inst_t;

endpackage

// File: rtl/mccu_decode.sv
// Instruction decoder: op/func -> one-hot instruction vector, valid flag, aluc, sext, shift.
// Latency: purely combinational, no state.
// Backpressure: none; outputs follow inputs.
// Ports: i_op, i_func in; o_inst (one-hot), o_inst_vld, o_aluc, o_sext, o_shift out.
module mccu_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output inst_t      o_inst,
  output logic       o_inst_vld,
  output logic [3:0] o_aluc,
  output logic       o_sext,
  output logic       o_shift
);

  inst_t w_inst;

  always_comb begin
    w_inst = '0;
    if (i_op == OP_RTYPE) begin
      case (i_func)
        FN_ADD:  w_inst.is_add = 1'b1;
        FN_SUB:  w_inst.is_sub = 1'b1;
        FN_AND:  w_inst.is_and = 1'b1;
        FN_OR:   w_inst.is_or  = 1'b1;
        FN_XOR:  w_inst.is_xor = 1'b1;
        FN_SLL:  w_inst.is_sll = 1'b1;
        FN_SRL:  w_inst.is_srl = 1'b1;
        FN_SRA:  w_inst.is_sra = 1'b1;
        FN_JR:   w_inst.is_jr  = 1'b1;
        default: ;
      endcase
    end else begin
      case (i_op)
        OP_ADDI: w_inst.is_addi = 1'b1;
        OP_ANDI: w_inst.is_andi = 1'b1;
        OP_ORI:  w_inst.is_ori  = 1'b1;
        OP_XORI: w_inst.is_xori = 1'b1;
        OP_LUI:  w_inst.is_lui  = 1'b1;
        OP_LW:   w_inst.is_lw   = 1'b1;
        OP_SW:   w_inst.is_sw   = 1'b1;
        OP_BEQ:  w_inst.is_beq  = 1'b1;
        OP_BNE:  w_inst.is_bne  = 1'b1;
        OP_J:    w_inst.is_j    = 1'b1;
        OP_JAL:  w_inst.is_jal  = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_aluc = ALUC_ADD;
    if (w_inst.is_sub | w_inst.is_beq | w_inst.is_bne) o_aluc = ALUC_SUB;
    else if (w_inst.is_and | w_inst.is_andi)           o_aluc = ALUC_AND;
    else if (w_inst.is_or  | w_inst.is_ori)            o_aluc = ALUC_OR;
    else if (w_inst.is_xor | w_inst.is_xori)           o_aluc = ALUC_XOR;
    else if (w_inst.is_lui)                            o_aluc = ALUC_LUI;
    else if (w_inst.is_sll)                            o_aluc = ALUC_SLL;
    else if (w_inst.is_srl)                            o_aluc = ALUC_SRL;
    else if (w_inst.is_sra)                            o_aluc = ALUC_SRA;
  end

  assign o_inst     = w_inst;
  assign o_inst_vld = |w_inst;
  assign o_sext     = w_inst.is_addi | w_inst.is_lw | w_inst.is_sw;
  assign o_shift    = w_inst.is_sll | w_inst.is_srl | w_inst.is_sra;

endmodule

// File: rtl/mccu.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB FSM driving ALU op and all datapath selects/enables.
// Latency (mready high): j/jal/jr 2, beq/bne 3, R/I-ALU/sw 4, lw 5 cycles; outputs combinational from state.
// Backpressure: mready low holds IF or MEM with every output stable; no other stalls.
// Optional feature: MCCU_ILLEGAL_TRAP_EN adds the ill port and a HALT state for undefined instructions.
// Ports: clk, rst (sync, active high), op, func, z, mready in;
//        aluc, wpc, wir, wmem, wreg, iord, alusrca, alusrcb, pcsource, regdst, m2reg, sext, shift, jal (, ill) out.
module mccu
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mready,
  output logic [3:0] aluc,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic       regdst,
  output logic       m2reg,
  output logic       sext,
  output logic       shift,
`ifdef MCCU_ILLEGAL_TRAP_EN
  output logic       ill,
`endif
  output logic       jal
);

  state_t     r_state;
  state_t     w_next;
  inst_t      w_inst;
  logic       w_inst_vld;
  logic [3:0] w_dec_aluc;
  logic       w_dec_sext;
  logic       w_dec_shift;
  logic       w_rtype;
  logic       w_ialu;
  logic       w_wpc;
  logic       w_wir;
  logic       w_wmem;
  logic       w_wreg;
`ifdef MCCU_ILLEGAL_TRAP_EN
  logic       w_ill;
`endif

  mccu_decode u_decode (
    .i_op       (op),
    .i_func     (func),
    .o_inst     (w_inst),
    .o_inst_vld (w_inst_vld),
    .o_aluc     (w_dec_aluc),
    .o_sext     (w_dec_sext),
    .o_shift    (w_dec_shift)
  );

  assign w_rtype = w_inst.is_add | w_inst.is_sub | w_inst.is_and | w_inst.is_or |
                   w_inst.is_xor | w_inst.is_sll | w_inst.is_srl | w_inst.is_sra;
  assign w_ialu  = w_inst.is_addi | w_inst.is_andi | w_inst.is_ori |
                   w_inst.is_xori | w_inst.is_lui;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IF;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    aluc     = ALUC_ADD;
    w_wpc    = 1'b0;
    w_wir    = 1'b0;
    w_wmem   = 1'b0;
    w_wreg   = 1'b0;
    iord     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REGB;
    pcsource = PCSRC_ALU;
    regdst   = 1'b0;
    m2reg    = 1'b0;
    sext     = 1'b0;
    shift    = 1'b0;
    jal      = 1'b0;
`ifdef MCCU_ILLEGAL_TRAP_EN
    w_ill    = 1'b0;
`endif
    case (r_state)
      S_IF: begin
        alusrcb = SRCB_FOUR;
        w_wpc   = mready;
        w_wir   = mready;
        if (mready) w_next = S_ID;
      end
      S_ID: begin
        // Branch target PC + sext(imm)<<2 is computed here regardless of opcode.
        alusrcb = SRCB_BRANCH;
        w_next  = S_EXE;
        if (w_inst.is_j | w_inst.is_jal) begin
          pcsource = PCSRC_JUMP;
          w_wpc    = 1'b1;
          w_wreg   = w_inst.is_jal;
          jal      = w_inst.is_jal;
          w_next   = S_IF;
        end else if (w_inst.is_jr) begin
          pcsource = PCSRC_REGA;
          w_wpc    = 1'b1;
          w_next   = S_IF;
        end else if (!w_inst_vld) begin
`ifdef MCCU_ILLEGAL_TRAP_EN
          w_ill  = 1'b1;
          w_next = S_HALT;
`else
          w_next = S_IF;
`endif
        end
      end
      S_EXE: begin
        w_next = S_IF;
        if (w_rtype) begin
          alusrca = 1'b1;
          aluc    = w_dec_aluc;
          shift   = w_dec_shift;
          w_next  = S_WB;
        end else if (w_inst.is_beq | w_inst.is_bne) begin
          aluc     = w_dec_aluc;
          alusrca  = 1'b1;
          pcsource = PCSRC_ALUOUT;
          w_wpc    = (w_inst.is_beq & z) | (w_inst.is_bne & ~z);
        end else if (w_ialu | w_inst.is_lw | w_inst.is_sw) begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          aluc    = w_dec_aluc;
          sext    = w_dec_sext;
          w_next  = (w_inst.is_lw | w_inst.is_sw) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        iord   = 1'b1;
        w_wmem = w_inst.is_sw;
        if (mready) w_next = w_inst.is_sw ? S_IF : S_WB;
      end
      S_WB: begin
        w_wreg = 1'b1;
        m2reg  = w_inst.is_lw;
        regdst = w_rtype;
        w_next = S_IF;
      end
`ifdef MCCU_ILLEGAL_TRAP_EN
      S_HALT: begin
        w_ill  = 1'b1;
        w_next = S_HALT;
      end
`endif
      default: w_next = S_IF;
    endcase
  end

  // Reset must block any architectural write in the cycle it is asserted.
  assign wpc  = w_wpc  & ~rst;
  assign wir  = w_wir  & ~rst;
  assign wmem = w_wmem & ~rst;
  assign wreg = w_wreg & ~rst;
`ifdef MCCU_ILLEGAL_TRAP_EN
  assign ill  = w_ill;
`endif

endmodule

// File: tb/tb_mccu.sv
// Directed testbench for mccu: walks instruction classes through the FSM
// and checks the combinational controls in each state against hand values.
module tb_mccu;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mready;
  logic [3:0] aluc;
  logic       wpc, wir, wmem, wreg, iord, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic       regdst, m2reg, sext, shift, jal;
`ifdef MCCU_ILLEGAL_TRAP_EN
  logic       ill;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mccu dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .func     (func),
    .z        (z),
    .mready   (mready),
    .aluc     (aluc),
    .wpc      (wpc),
    .wir      (wir),
    .wmem     (wmem),
    .wreg     (wreg),
    .iord     (iord),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .pcsource (pcsource),
    .regdst   (regdst),
    .m2reg    (m2reg),
    .sext     (sext),
    .shift    (shift),
`ifdef MCCU_ILLEGAL_TRAP_EN
    .ill      (ill),
`endif
    .jal      (jal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // IF state signature with mready high: fetch and PC+4 both written.
  task automatic check_if(input string tag);
    check({tag, "_srcb"}, alusrcb, 2'b01);
    check({tag, "_iord"}, iord, 1'b0);
    check({tag, "_wir"},  wir, 1'b1);
    check({tag, "_wpc"},  wpc, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mready = 1'b1; op = 6'h00; func = 6'h20; z = 1'b0;
    tick(); tick();
    // Reset: enables forced low even though IF with mready=1 would assert them.
    check("rst_wpc",  wpc,  1'b0);
    check("rst_wir",  wir,  1'b0);
    check("rst_wmem", wmem, 1'b0);
    check("rst_wreg", wreg, 1'b0);
    rst = 1'b0; #1;
    check_if("post_rst_if");

    // add: IF, ID, EXE, WB
    tick();
    check("add_id_srcb", alusrcb, 2'b11);
    check("add_id_aluc", aluc, 4'b0000);
    check("add_id_wpc",  wpc, 1'b0);
    tick();
    check("add_exe_aluc", aluc, 4'b0000);
    check("add_exe_srcb", alusrcb, 2'b00);
    check("add_exe_srca", alusrca, 1'b1);
    tick();
    check("add_wb_wreg",   wreg, 1'b1);
    check("add_wb_regdst", regdst, 1'b1);
    check("add_wb_m2reg",  m2reg, 1'b0);
    tick();
    check_if("add_done_if");

    // IF stall on mready low
    mready = 1'b0; #1;
    check("ifwait_wir", wir, 1'b0);
    check("ifwait_wpc", wpc, 1'b0);
    tick();
    check("ifwait2_srcb", alusrcb, 2'b01);
    check("ifwait2_wir",  wir, 1'b0);
    mready = 1'b1; #1;
    check_if("ifwait_release");

    // lw with two MEM wait cycles: IF ID EXE MEM MEM MEM WB = 7
    op = 6'h23;
    tick();
    check("lw_id_srcb", alusrcb, 2'b11);
    tick();
    check("lw_exe_srcb", alusrcb, 2'b10);
    check("lw_exe_sext", sext, 1'b1);
    check("lw_exe_aluc", aluc, 4'b0000);
    tick();
    mready = 1'b0; #1;
    check("lw_mem1_iord", iord, 1'b1);
    check("lw_mem1_wmem", wmem, 1'b0);
    tick();
    check("lw_mem2_iord", iord, 1'b1);
    tick();
    mready = 1'b1; #1;
    check("lw_mem3_iord", iord, 1'b1);
    tick();
    check("lw_wb_m2reg",  m2reg, 1'b1);
    check("lw_wb_wreg",   wreg, 1'b1);
    check("lw_wb_regdst", regdst, 1'b0);
    tick();
    check_if("lw_done_if");

    // beq taken
    op = 6'h04; z = 1'b1;
    tick(); tick();
    check("beq_t_aluc",  aluc, 4'b0100);
    check("beq_t_wpc",   wpc, 1'b1);
    check("beq_t_pcsrc", pcsource, 2'b01);
    tick();
    check_if("beq_t_if");

    // beq not taken
    z = 1'b0;
    tick(); tick();
    check("beq_nt_aluc",  aluc, 4'b0100);
    check("beq_nt_wpc",   wpc, 1'b0);
    check("beq_nt_pcsrc", pcsource, 2'b01);
    tick();
    check_if("beq_nt_if");

    // bne taken (z=0)
    op = 6'h05;
    tick(); tick();
    check("bne_t_wpc", wpc, 1'b1);
    tick();
    check_if("bne_if");

    // jal: 2 cycles
    op = 6'h03;
    tick();
    check("jal_id_pcsrc", pcsource, 2'b11);
    check("jal_id_wpc",   wpc, 1'b1);
    check("jal_id_wreg",  wreg, 1'b1);
    check("jal_id_jal",   jal, 1'b1);
    tick();
    check_if("jal_if");

    // jr
    op = 6'h00; func = 6'h08;
    tick();
    check("jr_id_pcsrc", pcsource, 2'b10);
    check("jr_id_wpc",   wpc, 1'b1);
    check("jr_id_wreg",  wreg, 1'b0);
    tick();
    check_if("jr_if");

    // sll
    func = 6'h00;
    tick(); tick();
    check("sll_exe_shift", shift, 1'b1);
    check("sll_exe_aluc",  aluc, 4'b0011);
    check("sll_exe_srcb",  alusrcb, 2'b00);
    tick();
    check("sll_wb_regdst", regdst, 1'b1);
    tick();
    check_if("sll_if");

    // ori: zero-extended immediate
    op = 6'h0D;
    tick(); tick();
    check("ori_exe_aluc", aluc, 4'b0101);
    check("ori_exe_sext", sext, 1'b0);
    check("ori_exe_srcb", alusrcb, 2'b10);
    tick();
    check("ori_wb_regdst", regdst, 1'b0);
    check("ori_wb_wreg",   wreg, 1'b1);
    tick();
    check_if("ori_if");

    // sw with reset mid-MEM handshake
    op = 6'h2B;
    tick(); tick(); tick();
    mready = 1'b0; #1;
    check("sw_mem_wmem", wmem, 1'b1);
    check("sw_mem_iord", iord, 1'b1);
    rst = 1'b1; #1;
    check("sw_rst_wmem", wmem, 1'b0);
    tick();
    rst = 1'b0; mready = 1'b1; #1;
    check_if("sw_rst_if");

    // Undefined opcode
    op = 6'h3F;
    tick();
    check("ill_id_wpc",  wpc, 1'b0);
    check("ill_id_wreg", wreg, 1'b0);
`ifdef MCCU_ILLEGAL_TRAP_EN
    check("ill_id_ill", ill, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_ill", ill, 1'b1);
      check("halt_wir", wir, 1'b0);
      check("halt_wpc", wpc, 1'b0);
      check("halt_wmem", wmem, 1'b0);
      check("halt_wreg", wreg, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("halt_rst_ill", ill, 1'b0);
    check_if("halt_rst_if");
`else
    tick();
    check_if("ill_nop_if");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
